// File: rtl/matrix_vector_engine.sv
// Fixed-point matrix-vector engine: loads a DIM x DIM matrix once per job, then
// streams input vectors through a one-MAC-per-cycle datapath with saturated write-back.
module matrix_vector_engine #(
  parameter int WIDTH = 32,
  parameter int DIM   = 4,
  parameter int FRAC  = 16,
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             transpose,
  input  logic [CNT_W-1:0] workItemCount,
  input  logic [WIDTH-1:0] matrixInAddr,
  input  logic [WIDTH-1:0] dataInAddr,
  input  logic [WIDTH-1:0] dataOutAddr,
  output logic             readEn,
  output logic [WIDTH-1:0] readAddr,
  input  logic             readValid,
  input  logic [WIDTH-1:0] dataIn,
  output logic             writeEn,
  output logic [WIDTH-1:0] writeAddr,
  output logic [WIDTH-1:0] writeData,
  input  logic             writeReady,
  output logic             busy,
  output logic             done
);

  localparam int BPW  = WIDTH / 8;
  localparam int NM   = DIM * DIM;
  localparam int MIW  = $clog2(NM);
  localparam int RCW  = $clog2(DIM);
  localparam int PW   = 2 * WIDTH;
  localparam int AW   = PW + RCW;

  typedef enum logic [2:0] {
    IDLE, LOAD_MAT, LOAD_VEC, MAC, WRITE, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mat_base_q, mat_base_d;
  logic [WIDTH-1:0]   in_base_q, in_base_d;
  logic [WIDTH-1:0]   out_base_q, out_base_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   item_q, item_d;
  logic               transpose_q, transpose_d;
  logic [MIW-1:0]     idx_q, idx_d;
  logic [RCW-1:0]     row_q, row_d;
  logic [RCW-1:0]     col_q, col_d;
  logic [AW-1:0]      acc_q, acc_d;

  logic [WIDTH-1:0]   mat_q [NM];
  logic [WIDTH-1:0]   vec_q [DIM];

  logic [WIDTH-1:0]   mat_addr, vec_addr, out_addr;
  logic [MIW-1:0]     midx;
  logic [WIDTH-1:0]   a_s, b_s;
  logic signed [PW-1:0] prod, prod_sh;
  logic [AW-1:0]      term;
  logic [AW-WIDTH:0]  acc_top;
  logic [WIDTH-1:0]   sat;

  always_comb begin
    mat_addr = mat_base_q + WIDTH'(idx_q) * WIDTH'(BPW);
    vec_addr = in_base_q + (WIDTH'(item_q) * WIDTH'(DIM) + WIDTH'(idx_q)) * WIDTH'(BPW);
    out_addr = out_base_q + (WIDTH'(item_q) * WIDTH'(DIM) + WIDTH'(row_q)) * WIDTH'(BPW);
  end

  // Transpose only swaps the matrix index; the vector is always walked by column.
  always_comb begin
    midx = transpose_q ? MIW'(int'(col_q) * DIM + int'(row_q))
                       : MIW'(int'(row_q) * DIM + int'(col_q));
    a_s     = mat_q[midx];
    b_s     = vec_q[col_q];
    prod    = {{WIDTH{a_s[WIDTH-1]}}, a_s} * {{WIDTH{b_s[WIDTH-1]}}, b_s};
    prod_sh = prod >>> FRAC;
    term    = {{RCW{prod_sh[PW-1]}}, prod_sh};
  end

  always_comb begin
    acc_top = acc_q[AW-1:WIDTH-1];
    if ((&acc_top) || !(|acc_top)) begin
      sat = acc_q[WIDTH-1:0];
    end else if (acc_q[AW-1]) begin
      sat = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      sat = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    state_d     = state_q;
    mat_base_d  = mat_base_q;
    in_base_d   = in_base_q;
    out_base_d  = out_base_q;
    count_d     = count_q;
    item_d      = item_q;
    transpose_d = transpose_q;
    idx_d       = idx_q;
    row_d       = row_q;
    col_d       = col_q;
    acc_d       = acc_q;
    readEn      = 1'b0;
    readAddr    = '0;
    writeEn     = 1'b0;
    writeAddr   = '0;
    writeData   = '0;
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mat_base_d  = matrixInAddr;
          in_base_d   = dataInAddr;
          out_base_d  = dataOutAddr;
          count_d     = workItemCount;
          transpose_d = transpose;
          item_d      = '0;
          idx_d       = '0;
          row_d       = '0;
          col_d       = '0;
          acc_d       = '0;
          state_d     = (workItemCount == '0) ? DONE : LOAD_MAT;
        end
      end
      LOAD_MAT: begin
        readEn   = 1'b1;
        readAddr = mat_addr;
        if (readValid) begin
          if (idx_q == MIW'(NM - 1)) begin
            idx_d   = '0;
            state_d = LOAD_VEC;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      LOAD_VEC: begin
        readEn   = 1'b1;
        readAddr = vec_addr;
        if (readValid) begin
          if (idx_q == MIW'(DIM - 1)) begin
            idx_d   = '0;
            row_d   = '0;
            col_d   = '0;
            state_d = MAC;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      MAC: begin
        // First column of a row restarts the sum instead of adding to it.
        acc_d = (col_q == '0) ? term : acc_q + term;
        if (col_q == RCW'(DIM - 1)) begin
          col_d   = '0;
          state_d = WRITE;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      WRITE: begin
        writeEn   = 1'b1;
        writeAddr = out_addr;
        writeData = sat;
        if (writeReady) begin
          if (row_q == RCW'(DIM - 1)) begin
            row_d = '0;
            if (item_q == count_q - CNT_W'(1)) begin
              state_d = DONE;
            end else begin
              item_d  = item_q + 1'b1;
              state_d = LOAD_VEC;
            end
          end else begin
            row_d   = row_q + 1'b1;
            state_d = MAC;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mat_base_q  <= '0;
      in_base_q   <= '0;
      out_base_q  <= '0;
      count_q     <= '0;
      item_q      <= '0;
      transpose_q <= 1'b0;
      idx_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      mat_base_q  <= mat_base_d;
      in_base_q   <= in_base_d;
      out_base_q  <= out_base_d;
      count_q     <= count_d;
      item_q      <= item_d;
      transpose_q <= transpose_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
    end
  end

  // Operand storage carries no reset; it is always fully reloaded before use.
  always_ff @(posedge clk) begin
    if (state_q == LOAD_MAT && readValid) begin
      mat_q[idx_q] <= dataIn;
    end
    if (state_q == LOAD_VEC && readValid) begin
      vec_q[RCW'(idx_q)] <= dataIn;
    end
  end

endmodule

// File: tb/tb_matrix_vector_engine.sv
// Directed self-checking bench for matrix_vector_engine (DIM=4, WIDTH=32, FRAC=16)
// with a word memory responder that can add read latency and write back-pressure.
module tb_matrix_vector_engine;

  logic        clk = 1'b0;
  logic        rst_n, start, transpose;
  logic [13:0] workItemCount;
  logic [31:0] matrixInAddr, dataInAddr, dataOutAddr;
  logic        readEn, readValid, writeEn, writeReady, busy, done;
  logic [31:0] readAddr, dataIn, writeAddr, writeData;

  matrix_vector_engine #(.WIDTH(32), .DIM(4), .FRAC(16), .CNT_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .transpose(transpose),
    .workItemCount(workItemCount), .matrixInAddr(matrixInAddr),
    .dataInAddr(dataInAddr), .dataOutAddr(dataOutAddr),
    .readEn(readEn), .readAddr(readAddr), .readValid(readValid), .dataIn(dataIn),
    .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
    .writeReady(writeReady), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] mem  [256];
  logic [31:0] matv [16];
  logic [31:0] vecv [12];
  logic [31:0] expv [12];
  logic [31:0] wa [64];
  logic [31:0] wd [64];
  int wn = 0, rd_cycles = 0, wr_cycles = 0;
  int rwait = 0, wwait = 0, cur_lat = 0, wlat = 0;
  bit rnd = 0;
  bit prev_rs = 0, prev_ws = 0;
  logic [31:0] prev_ra, prev_wa, prev_wd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Memory responder: decides readValid/writeReady at the falling edge, logs accepted writes.
  always @(negedge clk) begin
    if (!rst_n) begin
      readValid = 1'b0; writeReady = 1'b0; rwait = 0; wwait = 0;
      prev_rs = 0; prev_ws = 0;
    end else begin
      if (prev_rs) begin
        chk("rd_en_hold", readEn, 1);
        chk("rd_addr_hold", readAddr, prev_ra);
      end
      if (prev_ws) begin
        chk("wr_en_hold", writeEn, 1);
        chk("wr_addr_hold", writeAddr, prev_wa);
        chk("wr_data_hold", writeData, prev_wd);
      end
      if (readValid) begin
        rwait = 0;
        cur_lat = rnd ? int'($urandom_range(0, 5)) : 0;
      end
      if (writeReady) wwait = 0;
      readValid = 1'b0;
      writeReady = 1'b0;
      if (readEn) begin
        rd_cycles++;
        if (rwait >= cur_lat) begin
          readValid = 1'b1;
          dataIn = mem[readAddr[9:2]];
        end else rwait++;
      end
      if (writeEn) begin
        wr_cycles++;
        if (wwait >= wlat) begin
          writeReady = 1'b1;
          if (wn < 64) begin wa[wn] = writeAddr; wd[wn] = writeData; end
          wn++;
        end else wwait++;
      end
      prev_rs = readEn && !readValid; prev_ra = readAddr;
      prev_ws = writeEn && !writeReady; prev_wa = writeAddr; prev_wd = writeData;
    end
  end

  task automatic put_data();
    for (int k = 0; k < 256; k++) mem[k] = '0;
    for (int k = 0; k < 16; k++) mem[64 + k] = matv[k];
    for (int k = 0; k < 12; k++) mem[128 + k] = vecv[k];
  endtask

  task automatic run_job(input int cnt, input logic tr, input string tag, output int cyc);
    bit seen = 0;
    @(negedge clk);
    matrixInAddr = 32'h100; dataInAddr = 32'h200; dataOutAddr = 32'h300;
    workItemCount = 14'(cnt); transpose = tr; start = 1'b1; wn = 0;
    @(negedge clk);
    start = 1'b0;
    // Inputs scrambled after the start edge must not affect the job.
    matrixInAddr = 32'h0; dataInAddr = 32'h0; dataOutAddr = 32'h40;
    workItemCount = 14'd7; transpose = ~tr;
    cyc = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (i > 0) @(negedge clk);
      start = (i == 3 && cnt != 0);
      if (busy) cyc++;
      if (done) seen = 1;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic chk_out(input int items, input string tag);
    chk({tag, "_nwrites"}, wn, 4 * items);
    for (int k = 0; k < 4 * items; k++) begin
      chk($sformatf("%s_addr%0d", tag, k), wa[k], 32'h300 + 32'(4 * k));
      chk($sformatf("%s_data%0d", tag, k), wd[k], expv[k]);
    end
  endtask

  int cyc;

  initial begin
    rst_n = 1'b0; start = 1'b0; transpose = 1'b0; workItemCount = '0;
    matrixInAddr = '0; dataInAddr = '0; dataOutAddr = '0;
    readValid = 1'b0; writeReady = 1'b0; dataIn = '0;
    repeat (3) @(negedge clk);
    chk("rst_readEn", readEn, 0);
    chk("rst_writeEn", writeEn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_readAddr", readAddr, 0);
    chk("rst_writeAddr", writeAddr, 0);
    chk("rst_writeData", writeData, 0);
    rst_n = 1'b1;

    // Identity matrix passes the vector through.
    matv = '{32'h10000,0,0,0, 0,32'h10000,0,0, 0,0,32'h10000,0, 0,0,0,32'h10000};
    vecv = '{32'h10000,32'h20000,32'h30000,32'h40000, 0,0,0,0, 0,0,0,0};
    expv = '{32'h10000,32'h20000,32'h30000,32'h40000, 0,0,0,0, 0,0,0,0};
    put_data();
    run_job(1, 1'b0, "ident", cyc);
    chk("ident_busy_cycles", cyc, 41);
    chk_out(1, "ident");

    // Zero-length job.
    rd_cycles = 0; wr_cycles = 0;
    run_job(0, 1'b0, "zero", cyc);
    chk("zero_busy_cycles", cyc, 1);
    chk("zero_reads", rd_cycles, 0);
    chk("zero_writes", wr_cycles, 0);

    // Positive and negative saturation.
    matv = '{32'h7FFF0000,32'h7FFF0000,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    vecv = '{32'h20000,32'h20000,0,0, 0,0,0,0, 0,0,0,0};
    expv = '{32'h7FFFFFFF,0,0,0, 0,0,0,0, 0,0,0,0};
    put_data();
    run_job(1, 1'b0, "satpos", cyc);
    chk_out(1, "satpos");
    matv[0] = 32'h80010000; matv[1] = 32'h80010000;
    expv[0] = 32'h80000000;
    put_data();
    run_job(1, 1'b0, "satneg", cyc);
    chk_out(1, "satneg");

    // Transpose selection.
    matv = '{0,32'h10000,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    vecv = '{32'h10000,0,0,0, 0,0,0,0, 0,0,0,0};
    expv = '{0,32'h10000,0,0, 0,0,0,0, 0,0,0,0};
    put_data();
    run_job(1, 1'b1, "trans1", cyc);
    chk_out(1, "trans1");
    expv[1] = 0;
    run_job(1, 1'b0, "trans0", cyc);
    chk_out(1, "trans0");

    // Three items with mixed signs, a fractional weight and a floor-rounded product.
    matv = '{32'h10000,32'h20000,0,0, 0,32'hFFFF0000,0,0,
             32'h8000,0,0,32'h1, 0,0,0,32'h30000};
    vecv = '{32'h10000,32'h10000,32'h10000,32'h10000,
             32'h20000,0,0,32'hFFFF0000,
             32'hFFFF0000,32'h30000,0,32'hFFFF8000};
    expv = '{32'h30000,32'hFFFF0000,32'h8001,32'h30000,
             32'h20000,0,32'hFFFF,32'hFFFD0000,
             32'h50000,32'hFFFD0000,32'hFFFF7FFF,32'hFFFE8000};
    put_data();
    run_job(3, 1'b0, "multi", cyc);
    chk("multi_busy_cycles", cyc, 16 + 3 * 24 + 1);
    chk_out(3, "multi");
    rnd = 1; wlat = 3;
    run_job(3, 1'b0, "stall", cyc);
    chk_out(3, "stall");
    rnd = 0; wlat = 0; cur_lat = 0;

    // Reset during MAC of item 1, then a fresh job.
    @(negedge clk);
    matrixInAddr = 32'h100; dataInAddr = 32'h200; dataOutAddr = 32'h300;
    workItemCount = 14'd3; transpose = 1'b0; start = 1'b1; wn = 0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 500 && wn < 4; i++) @(negedge clk);
    chk("rst_mid_item0_written", 32'(wn >= 4), 1);
    @(negedge clk);
    for (int i = 0; i < 100 && readEn; i++) @(negedge clk);
    @(negedge clk);
    chk("rst_mid_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_readEn", readEn, 0);
    chk("rst_mid_writeEn", writeEn, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_readAddr", readAddr, 0);
    chk("rst_mid_writeAddr", writeAddr, 0);
    chk("rst_mid_writeData", writeData, 0);
    wn = 0; rd_cycles = 0; wr_cycles = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_after_writes", wn, 0);
    chk("rst_after_reads", rd_cycles, 0);
    chk("rst_after_wrcyc", wr_cycles, 0);
    chk("rst_after_busy", busy, 0);
    run_job(1, 1'b0, "postrst", cyc);
    chk_out(1, "postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
